tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
Receive-side counterpart of the team's time-division channel multiplexer. Accepts a serial stream of W-bit beats with a start-of-frame marker and routes slot k of each frame to output channel k. Completed frames are held in a double-buffered output register, so all CH channel outputs update atomically and stay stable until the next complete frame. Sits between the serial link and per-channel consumers in the mux/demux exercise chain.

Parameters:
CH, 4, number of channels (slots per frame); legal range 2..16.
W, 8, width of each beat and each channel, in bits.
SW (derived localparam), clog2(CH), width of the slot index.

Ports:
clk  input  1  single system clock; all logic is rising-edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  a beat is present on in_data this cycle.
in_sof  input  1  start of frame; meaningful only when in_valid=1; marks slot 0.
in_data  input  W  beat payload.
out_data  output  CH*W  channel k occupies bits [k*W +: W]; holds the last complete frame.
out_valid  output  1  one-cycle pulse when out_data has just been updated.
slot  output  SW  index of the next slot expected; 0 while IDLE.
frame_err  output  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (asynchronous assert, clocked release): state=IDLE; slot=0; out_data=0; out_valid=0; frame_err=0; shadow buffer=0.
- The FSM has two states, IDLE and RECV.
- IDLE:
  - A beat with in_valid=1 and in_sof=0 is dropped. No error is raised.
  - A beat with in_valid=1 and in_sof=1 writes in_data to shadow[0], sets slot=1 and moves to RECV.
- RECV:
  - A beat with in_valid=1 and in_sof=0 writes in_data to shadow[slot] and increments slot.
  - When the captured slot was CH-1:
    - On the next edge, out_data <= full shadow (including the final beat) and out_valid=1 for exactly one cycle.
    - slot returns to 0 and state returns to IDLE.
    - Latency is 1 cycle from acceptance of the last beat to out_valid high.
  - A cycle with in_valid=0 is a stall. State, slot and shadow hold. There is no timeout.
- in_sof=1 while in RECV (any slot ≠ 0) aborts the frame:
  - frame_err pulses for 1 cycle.
  - The partial shadow content is discarded: it is never presented, and out_data is unchanged.
  - The same beat is taken as slot 0 of a new frame: shadow[0]=in_data, slot=1, state stays RECV.
- Back-to-back frames: an in_sof beat in the cycle immediately after the last slot is accepted with no bubble. The out_valid pulse for the previous frame and capture of the new slot 0 occur in the same cycle.
- out_data changes only on a completed frame. It is never partially updated.
- out_valid and frame_err are never high in the same cycle for the same frame.
- in_sof is ignored when in_valid=0.
- Reset asserted mid-frame: everything returns to reset values immediately. No out_valid or frame_err is generated for the aborted frame.
- No backpressure: the block accepts every valid beat.

Test Plan:
- Reset check: hold rst=1 for 2 cycles, then release. Required: out_data=0, out_valid=0, frame_err=0, slot=0. Assert rst asynchronously mid-cycle and confirm outputs clear without waiting for a clock edge.
- Single frame, CH=4, W=8: send beats 0x11(sof), 0x22, 0x33, 0x44 on consecutive cycles. Required: out_valid pulses 1 cycle after the 0x44 beat, and out_data=0x44332211. Verify that slot sequence 1,2,3,0 is visible.
- Stalls and pre-frame junk: send 0xAA, 0xBB without sof, then a frame 0x01(sof), 0x02, 0x03, 0x04 with in_valid=0 gaps of 1–3 cycles between beats. Required: junk beats ignored, out_data=0x04030201, exactly one out_valid pulse.
- Abort: send 0x10(sof), 0x20, then 0x30(sof), 0x40, 0x50, 0x60. Required: frame_err pulses once at the 0x30 beat; out_data keeps its prior value until the new frame completes, then becomes 0x60504030.
- Back-to-back: send two frames with no gap, 0x01..0x04 then 0x05..0x08. Required: two out_valid pulses 4 cycles apart; out_data=0x04030201, then 0x08070605.
- Reset mid-frame: send 0x11(sof), 0x22, assert rst, release, then send 0x55(sof), 0x66, 0x77, 0x88. Required: no out_valid for the first frame, and final out_data=0x88776655. Also run with $random beats and sof to confirm out_data only changes on out_valid.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux -- receive side of the time-division channel mux.
//
// Takes a serial stream of W-bit beats framed by a start-of-frame marker and
// routes slot k of every frame to output channel k. Beats are collected in a
// shadow buffer; only a fully received frame is copied into out_data, so all
// channels update together and hold until the next complete frame.
//
// Parameters:
//   CH  number of channels / slots per frame (2..16)
//   W   width of a beat and of each channel
//   SW  derived slot-index width, clog2(CH)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   beat present on in_data
//   in_sof     start of frame (slot 0), qualified by in_valid
//   in_data    beat payload
//   out_data   channel k at bits [k*W +: W], last complete frame
//   out_valid  one-cycle pulse when out_data has just been updated
//   slot       index of the next expected slot (0 while idle)
//   frame_err  one-cycle pulse when a frame is aborted by an early in_sof
module tdm_demux #(
  parameter int CH = 4,
  parameter int W  = 8,
  localparam int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [W-1:0]    in_data,
  output logic [CH*W-1:0] out_data,
  output logic            out_valid,
  output logic [SW-1:0]   slot,
  output logic            frame_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [SW-1:0] LAST_SLOT  = SW'(CH - 1);
  localparam logic [SW-1:0] FIRST_NEXT = SW'(1);

  state_t state;

  // A sof beat is always accepted (new frame, or restart of an aborted one);
  // a plain beat is only accepted while a frame is in progress.
  logic            accept_sof;
  logic            accept_cont;
  logic            capture;
  logic [SW-1:0]   cap_idx;
  logic [CH*W-1:0] frame_next;

  assign accept_sof  = in_valid && in_sof;
  assign accept_cont = in_valid && !in_sof && (state == RECV);
  assign capture     = accept_sof || accept_cont;
  assign cap_idx     = accept_sof ? '0 : slot;

  // Shadow buffer, one lane per slot. The final slot never needs storage:
  // its beat is the one completing the frame, so it is taken straight from
  // in_data when the frame is copied to the output.
  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    if (gi < CH - 1) begin : g_store
      logic [W-1:0] lane_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (capture && (cap_idx == SW'(gi))) begin
          lane_reg <= in_data;
        end
      end

      assign frame_next[gi*W +: W] = lane_reg;
    end else begin : g_final
      assign frame_next[gi*W +: W] = in_data;
    end
  end

  // Frame FSM. Outputs are registered; out_valid and frame_err are
  // single-cycle pulses cleared by default every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // Beats without sof are junk between frames and are dropped.
          if (accept_sof) begin
            slot  <= FIRST_NEXT;
            state <= RECV;
          end
        end
        RECV: begin
          if (accept_sof) begin
            // Early sof: the partial frame is discarded (out_data untouched)
            // and this beat becomes slot 0 of the next frame.
            frame_err <= 1'b1;
            slot      <= FIRST_NEXT;
          end else if (accept_cont) begin
            if (slot == LAST_SLOT) begin
              out_data  <= frame_next;
              out_valid <= 1'b1;
              slot      <= '0;
              state     <= IDLE;
            end else begin
              slot <= slot + FIRST_NEXT;
            end
          end
        end
        default: begin
          state <= IDLE;
          slot  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int SW = $clog2(CH);

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_sof;
  logic [W-1:0]    in_data;
  logic [CH*W-1:0] out_data;
  logic            out_valid;
  logic [SW-1:0]   slot;
  logic            frame_err;

  int checks;
  int failures;

  tdm_demux #(.CH(CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .slot      (slot),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            v;
    logic            s;
    logic [W-1:0]    d;
    logic            ev;
    logic            ee;
    int              es;
    logic [CH*W-1:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic s, input logic [W-1:0] d,
                              input logic ev, input logic ee, input int es,
                              input logic [CH*W-1:0] ed);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.ev = ev; r.ee = ee; r.es = es; r.ed = ed;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic ee, input int es,
                         input logic [CH*W-1:0] ed);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".frame_err"}, 64'(frame_err), 64'(ee));
    chk({tag, ".slot"},      64'(slot),      64'(es));
    chk({tag, ".out_data"},  64'(out_data),  64'(ed));
  endtask

  // Apply one beat for one clock, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a frame is just the list of beats collected since sof.
  logic [W-1:0]    m_q[$];
  logic [CH*W-1:0] m_data;
  logic            m_ov;
  logic            m_err;

  function automatic void model_beat(input logic v, input logic s, input logic [W-1:0] d);
    m_ov  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (s) begin
        if (m_q.size() != 0) m_err = 1'b1;
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() != 0) begin
        m_q.push_back(d);
        if (m_q.size() == CH) begin
          for (int k = 0; k < CH; k++) m_data[k*W +: W] = m_q[k];
          m_ov = 1'b1;
          m_q.delete();
        end
      end
    end
  endfunction

  initial begin
    logic [CH*W-1:0] prev;
    int              ovs;
    checks   = 0;
    failures = 0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;

    // ---- reset ----
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_hold", 1'b0, 1'b0, 0, '0);
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    chk_all("reset_rel", 1'b0, 1'b0, 0, '0);

    // ---- table-driven directed scenarios ----
    // single frame
    add(1,1,8'h11, 0,0,1, 32'h0);
    add(1,0,8'h22, 0,0,2, 32'h0);
    add(1,0,8'h33, 0,0,3, 32'h0);
    add(1,0,8'h44, 1,0,0, 32'h44332211);
    add(0,0,8'h00, 0,0,0, 32'h44332211);
    // junk before frame, stalls between beats, sof while in_valid=0 ignored
    add(1,0,8'hAA, 0,0,0, 32'h44332211);
    add(1,0,8'hBB, 0,0,0, 32'h44332211);
    add(1,1,8'h01, 0,0,1, 32'h44332211);
    add(0,0,8'h00, 0,0,1, 32'h44332211);
    add(1,0,8'h02, 0,0,2, 32'h44332211);
    add(0,0,8'h00, 0,0,2, 32'h44332211);
    add(0,0,8'h00, 0,0,2, 32'h44332211);
    add(1,0,8'h03, 0,0,3, 32'h44332211);
    add(0,0,8'h00, 0,0,3, 32'h44332211);
    add(0,1,8'hFF, 0,0,3, 32'h44332211);
    add(0,0,8'h00, 0,0,3, 32'h44332211);
    add(1,0,8'h04, 1,0,0, 32'h04030201);
    add(0,0,8'h00, 0,0,0, 32'h04030201);
    // abort by early sof
    add(1,1,8'h10, 0,0,1, 32'h04030201);
    add(1,0,8'h20, 0,0,2, 32'h04030201);
    add(1,1,8'h30, 0,1,1, 32'h04030201);
    add(1,0,8'h40, 0,0,2, 32'h04030201);
    add(1,0,8'h50, 0,0,3, 32'h04030201);
    add(1,0,8'h60, 1,0,0, 32'h60504030);
    add(0,0,8'h00, 0,0,0, 32'h60504030);
    // back-to-back frames
    add(1,1,8'h01, 0,0,1, 32'h60504030);
    add(1,0,8'h02, 0,0,2, 32'h60504030);
    add(1,0,8'h03, 0,0,3, 32'h60504030);
    add(1,0,8'h04, 1,0,0, 32'h04030201);
    add(1,1,8'h05, 0,0,1, 32'h04030201);
    add(1,0,8'h06, 0,0,2, 32'h04030201);
    add(1,0,8'h07, 0,0,3, 32'h04030201);
    add(1,0,8'h08, 1,0,0, 32'h08070605);
    add(0,0,8'h00, 0,0,0, 32'h08070605);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ee, tbl[i].es, tbl[i].ed);
      $display("vec %0d: v=%0d sof=%0d d=%02h -> ov=%0d err=%0d slot=%0d data=%08h",
               i, tbl[i].v, tbl[i].s, tbl[i].d, out_valid, frame_err, slot, out_data);
    end

    // ---- asynchronous reset mid-cycle clears outputs before any edge ----
    step(1'b1, 1'b1, 8'h99);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 0, '0);
    $display("async reset mid-cycle: slot=%0d data=%08h", slot, out_data);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    step(1'b0, 1'b0, 8'h00);

    // ---- reset mid-frame ----
    step(1'b1, 1'b1, 8'h11);
    chk_all("mid_a", 1'b0, 1'b0, 1, '0);
    step(1'b1, 1'b0, 8'h22);
    chk_all("mid_b", 1'b0, 1'b0, 2, '0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("mid_rst", 1'b0, 1'b0, 0, '0);
    @(posedge clk);
    #1;
    chk_all("mid_rst_edge", 1'b0, 1'b0, 0, '0);
    rst = 1'b0;
    step(1'b1, 1'b1, 8'h55);
    chk_all("mid_c", 1'b0, 1'b0, 1, '0);
    step(1'b1, 1'b0, 8'h66);
    step(1'b1, 1'b0, 8'h77);
    chk_all("mid_d", 1'b0, 1'b0, 3, '0);
    step(1'b1, 1'b0, 8'h88);
    chk_all("mid_done", 1'b1, 1'b0, 0, 32'h88776655);
    $display("reset mid-frame: final data=%08h ov=%0d", out_data, out_valid);
    step(1'b0, 1'b0, 8'h00);

    // ---- randomized stream against the frame-list model ----
    m_q.delete();
    m_data = 32'h88776655;
    ovs    = 0;
    for (int i = 0; i < 3000; i++) begin
      logic            v;
      logic            s;
      logic [W-1:0]    d;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 2);
      d = W'($urandom);
      prev = out_data;
      model_beat(v, s, d);
      step(v, s, d);
      chk_all($sformatf("rnd%0d", i), m_ov, m_err, m_q.size(), m_data);
      checks++;
      if (!out_valid && out_data !== prev) begin
        failures++;
        $display("FAIL rnd%0d.stable: out_data 0x%0h changed from 0x%0h without out_valid",
                 i, out_data, prev);
      end
      if (out_valid) ovs++;
      if (out_valid || frame_err)
        $display("rnd %0d: ov=%0d err=%0d data=%08h", i, out_valid, frame_err, out_data);
    end
    $display("random phase: %0d frames delivered", ovs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
